// File: rtl/dmem_arbiter_ctrl.sv
// dmem_arbiter_ctrl: round-robin sharing of the 32-word data memory between
// the CPU load/store port (port 0) and the debug/init port (port 1).
// Each access runs IDLE -> ACCESS -> RESP, one access every 3 cycles.
module dmem_arbiter_ctrl #(
    parameter int unsigned DEPTH_WORDS = 32,
    parameter int unsigned AW          = 11
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [1:0]    p0_size,
    input  logic          p0_signed,
    input  logic [31:0]   p0_addr,
    input  logic [31:0]   p0_wdata,
    output logic          p0_gnt,
    output logic          p0_rvalid,
    output logic [31:0]   p0_rdata,
    output logic          p0_err,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [1:0]    p1_size,
    input  logic          p1_signed,
    input  logic [31:0]   p1_addr,
    input  logic [31:0]   p1_wdata,
    output logic          p1_gnt,
    output logic          p1_rvalid,
    output logic [31:0]   p1_rdata,
    output logic          p1_err,
    output logic          dm_wena,
    output logic [1:0]    dm_in_type,
    output logic [1:0]    dm_addr_tail,
    output logic [AW-1:0] dm_addr,
    output logic [31:0]   dm_data32,
    output logic [15:0]   dm_data16,
    output logic [7:0]    dm_data8,
    input  logic [31:0]   dm_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        last_grant_q;   // port id of the most recent grant
    logic        owner_q;
    logic        we_q;
    logic        signed_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [31:0] rdata_q;
    logic        err_q;

    logic        grant0, grant1;
    logic        bad;
    logic [15:0] half_f;
    logic [7:0]  byte_f;
    logic [31:0] load_val;

    // Next state, arbitration and response-port decode
    always_comb begin
        state_d   = state_q;
        grant0    = 1'b0;
        grant1    = 1'b0;
        p0_rvalid = 1'b0;
        p1_rvalid = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                // gnt is forced low while reset is asserted
                if (!rst) begin
                    if (p0_req && p1_req) begin
                        grant0 = last_grant_q;
                        grant1 = ~last_grant_q;
                    end else begin
                        grant0 = p0_req;
                        grant1 = p1_req;
                    end
                end
                if (grant0 || grant1) begin
                    state_d = S_ACCESS;
                end
            end
            S_ACCESS: state_d = S_RESP;
            S_RESP: begin
                p0_rvalid = ~owner_q;
                p1_rvalid = owner_q;
                state_d   = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Latch the winning request and update round-robin pointer
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
            owner_q      <= 1'b0;
            we_q         <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= 2'b00;
            addr_q       <= '0;
            wdata_q      <= '0;
        end else if (grant0 || grant1) begin
            last_grant_q <= grant1;
            owner_q      <= grant1;
            we_q         <= grant1 ? p1_we     : p0_we;
            signed_q     <= grant1 ? p1_signed : p0_signed;
            size_q       <= grant1 ? p1_size   : p0_size;
            addr_q       <= grant1 ? p1_addr   : p0_addr;
            wdata_q      <= grant1 ? p1_wdata  : p0_wdata;
        end
    end

    // Misalignment, illegal size and out-of-range detection
    always_comb begin
        bad = 1'b0;
        case (size_q)
            2'b11:   bad = 1'b1;
            2'b01:   bad = addr_q[0];
            2'b00:   bad = (addr_q[1:0] != 2'b00);
            default: bad = 1'b0;
        endcase
        if (addr_q >= 32'(4 * DEPTH_WORDS)) begin
            bad = 1'b1;
        end
    end

    // Load field selection and sign/zero extension
    always_comb begin
        half_f = addr_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        case (addr_q[1:0])
            2'd0:    byte_f = dm_rdata[7:0];
            2'd1:    byte_f = dm_rdata[15:8];
            2'd2:    byte_f = dm_rdata[23:16];
            default: byte_f = dm_rdata[31:24];
        endcase
        case (size_q)
            2'b00:   load_val = dm_rdata;
            2'b01:   load_val = {{16{signed_q & half_f[15]}}, half_f};
            default: load_val = {{24{signed_q & byte_f[7]}}, byte_f};
        endcase
    end

    // Capture the response at the end of ACCESS
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else if (state_q == S_ACCESS) begin
            rdata_q <= (we_q || bad) ? 32'h0 : load_val;
            err_q   <= bad;
        end
    end

    assign p0_gnt    = grant0;
    assign p1_gnt    = grant1;
    assign p0_rdata  = p0_rvalid ? rdata_q : 32'h0;
    assign p1_rdata  = p1_rvalid ? rdata_q : 32'h0;
    assign p0_err    = p0_rvalid & err_q;
    assign p1_err    = p1_rvalid & err_q;

    // Write enable follows the async-reset state, so it drops at once on rst
    assign dm_wena      = (state_q == S_ACCESS) & we_q & ~bad;
    assign dm_in_type   = size_q;
    assign dm_addr_tail = addr_q[1:0];
    assign dm_addr      = addr_q[AW+1:2];
    assign dm_data32    = wdata_q;
    assign dm_data16    = wdata_q[15:0];
    assign dm_data8     = wdata_q[7:0];

endmodule

// File: tb/tb_dmem_arbiter_ctrl.sv
// Bench for dmem_arbiter_ctrl: byte-array reference model plus a cycle
// monitor predicting grants, DMEM strobes and responses.
module tb_dmem_arbiter_ctrl;

    localparam int DEPTH = 32;
    localparam int AW    = 11;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          p0_req = 1'b0, p0_we = 1'b0, p0_signed = 1'b0;
    logic [1:0]    p0_size = 2'b00;
    logic [31:0]   p0_addr = '0, p0_wdata = '0;
    logic          p0_gnt, p0_rvalid, p0_err;
    logic [31:0]   p0_rdata;
    logic          p1_req = 1'b0, p1_we = 1'b0, p1_signed = 1'b0;
    logic [1:0]    p1_size = 2'b00;
    logic [31:0]   p1_addr = '0, p1_wdata = '0;
    logic          p1_gnt, p1_rvalid, p1_err;
    logic [31:0]   p1_rdata;
    logic          dm_wena;
    logic [1:0]    dm_in_type, dm_addr_tail;
    logic [AW-1:0] dm_addr;
    logic [31:0]   dm_data32;
    logic [15:0]   dm_data16;
    logic [7:0]    dm_data8;
    logic [31:0]   dm_rdata;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    dmem_arbiter_ctrl #(.DEPTH_WORDS(DEPTH), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .p0_req(p0_req), .p0_we(p0_we), .p0_size(p0_size), .p0_signed(p0_signed),
        .p0_addr(p0_addr), .p0_wdata(p0_wdata), .p0_gnt(p0_gnt),
        .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata), .p0_err(p0_err),
        .p1_req(p1_req), .p1_we(p1_we), .p1_size(p1_size), .p1_signed(p1_signed),
        .p1_addr(p1_addr), .p1_wdata(p1_wdata), .p1_gnt(p1_gnt),
        .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata), .p1_err(p1_err),
        .dm_wena(dm_wena), .dm_in_type(dm_in_type), .dm_addr_tail(dm_addr_tail),
        .dm_addr(dm_addr), .dm_data32(dm_data32), .dm_data16(dm_data16),
        .dm_data8(dm_data8), .dm_rdata(dm_rdata)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Environment DMEM: word array with combinational read
    logic [31:0] dmem [DEPTH];

    always_comb begin
        dm_rdata = (int'(dm_addr) < DEPTH) ? dmem[dm_addr[4:0]] : 32'h0;
    end

    always @(posedge clk) begin
        if (dm_wena && int'(dm_addr) < DEPTH) begin
            case (dm_in_type)
                2'b00: dmem[dm_addr[4:0]] <= dm_data32;
                2'b01: begin
                    if (dm_addr_tail[1]) dmem[dm_addr[4:0]][31:16] <= dm_data16;
                    else                 dmem[dm_addr[4:0]][15:0]  <= dm_data16;
                end
                default: dmem[dm_addr[4:0]][8*dm_addr_tail +: 8] <= dm_data8;
            endcase
        end
    end

    always @(posedge clk) cyc++;

    // Reference model: little-endian byte array
    logic [7:0] ref_mem [4*DEPTH];

    function automatic int nbytes(input logic [1:0] size);
        return (size == 2'b00) ? 4 : (size == 2'b01) ? 2 : 1;
    endfunction

    function automatic bit is_bad(input logic [1:0] size, input logic [31:0] addr);
        if (size == 2'b11) return 1'b1;
        if (addr >= 32'(4 * DEPTH)) return 1'b1;
        return (addr % nbytes(size)) != 0;
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] size, input bit sgn,
                                             input logic [31:0] addr);
        logic [31:0] v = 32'h0;
        int n = nbytes(size);
        for (int i = 0; i < n; i++) v |= 32'(ref_mem[addr + 32'(i)]) << (8 * i);
        if (sgn && n < 4 && v[8*n-1]) v |= 32'hFFFF_FFFF << (8 * n);
        return v;
    endfunction

    typedef struct { int port; int cyc; } glog_t;
    glog_t glog[$];

    int          busy_until = 0;
    bit          last_g = 1'b1;
    bit          acc_v = 1'b0, rsp_v = 1'b0;
    int          acc_cyc, rsp_cyc;
    bit          acc_port, acc_we, acc_sgn, rsp_port, rsp_err;
    logic [1:0]  acc_size;
    logic [31:0] acc_addr, acc_wdata, rsp_data;

    // Cycle monitor: predicts every grant, DMEM strobe and response
    always @(negedge clk) begin
        bit idle, eg0, eg1, erv0, erv1, ewe, b;
        if (rst) begin
            acc_v = 1'b0;
            rsp_v = 1'b0;
            busy_until = 0;
            last_g = 1'b1;
        end else begin
            erv0 = rsp_v && cyc == rsp_cyc && !rsp_port;
            erv1 = rsp_v && cyc == rsp_cyc && rsp_port;
            check("p0_rvalid", p0_rvalid, erv0);
            check("p1_rvalid", p1_rvalid, erv1);
            if (erv0) begin
                check("p0_rdata", p0_rdata, rsp_data);
                check("p0_err", p0_err, rsp_err);
            end
            if (erv1) begin
                check("p1_rdata", p1_rdata, rsp_data);
                check("p1_err", p1_err, rsp_err);
            end
            if (rsp_v && cyc >= rsp_cyc) rsp_v = 1'b0;

            ewe = 1'b0;
            if (acc_v && cyc == acc_cyc) begin
                b = is_bad(acc_size, acc_addr);
                ewe = acc_we && !b;
                check("dm_addr", 32'(dm_addr), (acc_addr / 4) % 2048);
                check("dm_in_type", 32'(dm_in_type), 32'(acc_size));
                check("dm_addr_tail", 32'(dm_addr_tail), acc_addr % 4);
                if (ewe) begin
                    check("dm_data32", dm_data32, acc_wdata);
                    check("dm_data16", 32'(dm_data16), acc_wdata % 65536);
                    check("dm_data8", 32'(dm_data8), acc_wdata % 256);
                    for (int i = 0; i < nbytes(acc_size); i++)
                        ref_mem[acc_addr + 32'(i)] = 8'((acc_wdata >> (8 * i)) % 256);
                end
                rsp_data = (acc_we || b) ? 32'h0 : ref_load(acc_size, acc_sgn, acc_addr);
                rsp_err  = b;
                rsp_port = acc_port;
                rsp_cyc  = cyc + 1;
                rsp_v    = 1'b1;
                acc_v    = 1'b0;
            end
            check("dm_wena", dm_wena, ewe);

            idle = (cyc >= busy_until);
            eg0  = idle && p0_req && (!p1_req || last_g);
            eg1  = idle && p1_req && (!p0_req || !last_g);
            check("p0_gnt", p0_gnt, eg0);
            check("p1_gnt", p1_gnt, eg1);
            if (p0_gnt) glog.push_back('{0, cyc});
            if (p1_gnt) glog.push_back('{1, cyc});
            if (eg0 || eg1) begin
                acc_port  = eg1;
                acc_we    = eg1 ? p1_we     : p0_we;
                acc_size  = eg1 ? p1_size   : p0_size;
                acc_sgn   = eg1 ? p1_signed : p0_signed;
                acc_addr  = eg1 ? p1_addr   : p0_addr;
                acc_wdata = eg1 ? p1_wdata  : p0_wdata;
                acc_cyc   = cyc + 1;
                acc_v     = 1'b1;
                busy_until = cyc + 3;
                last_g    = eg1;
            end
        end
    end

    // Present a request at posedge+1 and hold it until granted
    task automatic drive(input int port, input bit we, input logic [1:0] size,
                         input bit sgn, input logic [31:0] addr, input logic [31:0] wdata);
        bit got = 1'b0;
        if (port == 0) begin
            p0_we = we; p0_size = size; p0_signed = sgn; p0_addr = addr; p0_wdata = wdata;
            p0_req = 1'b1;
        end else begin
            p1_we = we; p1_size = size; p1_signed = sgn; p1_addr = addr; p1_wdata = wdata;
            p1_req = 1'b1;
        end
        for (int k = 0; k < 40 && !got; k++) begin
            @(negedge clk);
            got = (port == 0) ? p0_gnt : p1_gnt;
        end
        if (!got) check("gnt_timeout", 32'(got), 32'd1);
        @(posedge clk);
        #1;
        if (port == 0) p0_req = 1'b0;
        else           p1_req = 1'b0;
    endtask

    // Port-0 load with a fixed expected result, sampled in RESP
    task automatic load_const(input string tag, input logic [1:0] size, input bit sgn,
                              input logic [31:0] addr, input logic [31:0] exp);
        drive(0, 1'b0, size, sgn, addr, 32'h0);
        @(posedge clk);
        #1;
        check({tag, "_rvalid"}, 32'(p0_rvalid), 32'd1);
        check(tag, p0_rdata, exp);
    endtask

    task automatic rand_port(input int port, input int n);
        logic [1:0]  size;
        logic [31:0] addr;
        int gap;
        for (int i = 0; i < n; i++) begin
            size = 2'($urandom_range(0, 3));
            addr = $urandom_range(0, 159);
            if ($urandom_range(0, 1) == 1 && size != 2'b11) addr = addr & ~32'(nbytes(size) - 1);
            drive(port, 1'($urandom_range(0, 1)), size, 1'($urandom_range(0, 1)), addr, $urandom);
            gap = $urandom_range(0, 2);
            if (gap > 0) begin
                repeat (gap) @(posedge clk);
                #1;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        for (int i = 0; i < DEPTH; i++) begin
            w = $urandom;
            dmem[i] = w;
            for (int j = 0; j < 4; j++) ref_mem[4*i+j] = 8'((w >> (8 * j)) % 256);
        end

        // Both ports already requesting while in reset: outputs held at zero
        p0_addr = 32'h10; p1_addr = 32'h20;
        p0_req = 1'b1; p1_req = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_p0_gnt", 32'(p0_gnt), 32'd0);
        check("rst_p1_gnt", 32'(p1_gnt), 32'd0);
        check("rst_dm_wena", 32'(dm_wena), 32'd0);
        check("rst_dm_addr", 32'(dm_addr), 32'd0);
        check("rst_dm_data32", dm_data32, 32'd0);
        check("rst_p0_rdata", p0_rdata, 32'd0);
        rst = 1'b0;

        // Continuous requests from both ports: alternating 3 cycles apart
        glog.delete();
        fork
            for (int i = 0; i < 3; i++) drive(0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0);
            for (int i = 0; i < 3; i++) drive(1, 1'b0, 2'b00, 1'b0, 32'h20, 32'h0);
        join
        check("rr_count", 32'(glog.size()), 32'd6);
        for (int i = 0; i < glog.size() && i < 6; i++) begin
            check("rr_port", 32'(glog[i].port), 32'(i % 2));
            check("rr_spacing", 32'(glog[i].cyc - glog[0].cyc), 32'(3 * i));
        end
        repeat (3) @(posedge clk);
        #1;

        // Directed store/load and extraction
        drive(0, 1'b1, 2'b00, 1'b0, 32'h10, 32'hDEADBEEF);
        load_const("lw_10", 2'b00, 1'b0, 32'h10, 32'hDEADBEEF);
        load_const("lb_13", 2'b10, 1'b1, 32'h13, 32'hFFFFFFDE);
        load_const("lbu_13", 2'b10, 1'b0, 32'h13, 32'h000000DE);
        load_const("lh_12", 2'b01, 1'b1, 32'h12, 32'hFFFFDEAD);
        load_const("lhu_10", 2'b01, 1'b0, 32'h10, 32'h0000BEEF);
        drive(0, 1'b1, 2'b10, 1'b0, 32'h11, 32'h00000055);
        load_const("lw_10_sb", 2'b00, 1'b0, 32'h10, 32'hDEAD55EF);

        // Error cases: nothing written, rdata forced to 0
        drive(0, 1'b1, 2'b00, 1'b0, 32'h12, 32'h11111111);
        load_const("lw_80", 2'b00, 1'b0, 32'h80, 32'h0);
        check("lw_80_err", 32'(p0_err), 32'd1);
        drive(1, 1'b1, 2'b11, 1'b0, 32'h10, 32'h22222222);
        drive(1, 1'b1, 2'b01, 1'b0, 32'h7F, 32'h33333333);
        load_const("lw_10_err", 2'b00, 1'b0, 32'h10, 32'hDEAD55EF);

        // Reset in the middle of a store's ACCESS cycle
        drive(0, 1'b1, 2'b00, 1'b0, 32'h14, 32'h12345678);
        rst = 1'b1;
        #1;
        check("mid_rst_wena", 32'(dm_wena), 32'd0);
        check("mid_rst_addr", 32'(dm_addr), 32'd0);
        check("mid_rst_data32", dm_data32, 32'd0);
        check("mid_rst_p0_rvalid", 32'(p0_rvalid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        glog.delete();
        fork
            drive(0, 1'b0, 2'b00, 1'b0, 32'h14, 32'h0);
            drive(1, 1'b0, 2'b00, 1'b0, 32'h14, 32'h0);
        join
        check("post_rst_tie", (glog.size() > 0) ? 32'(glog[0].port) : 32'd9, 32'd0);

        // Randomised traffic from both ports
        fork
            rand_port(0, 60);
            rand_port(1, 60);
        join
        repeat (5) @(posedge clk);
        #1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter_ctrl.md
Name: dmem_arbiter_ctrl

Overview:
- Sequences and shares the 32-word data memory (DMEM) between two requesters: the CPU load/store port (port 0) and a debug/initialisation port (port 1).
- Accepts byte-addressed load/store requests and arbitrates between them round-robin.
- Drives the DMEM word address, size code, byte tail, write enable and the 32/16/8-bit write data.
- Extracts and sign/zero-extends load data, and flags misaligned or out-of-range accesses. One access completes every 3 cycles.

Parameters:
- DEPTH_WORDS, 32, number of DMEM words; byte range is 0 .. 4*DEPTH_WORDS-1.
- AW, 11, DMEM word-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- p0_req  in  1  port 0 request; held until p0_gnt.
- p0_we  in  1  1 = store, 0 = load.
- p0_size  in  2  00 word, 01 halfword, 10 byte; 11 is illegal and reported as err.
- p0_signed  in  1  load sign-extension enable.
- p0_addr  in  32  byte address.
- p0_wdata  in  32  store data, right-aligned.
- p0_gnt  out  1  one-cycle accept pulse.
- p0_rvalid  out  1  one-cycle completion pulse.
- p0_rdata  out  32  load result; 0 for stores and errors.
- p0_err  out  1  valid with p0_rvalid.
- p1_req, p1_we, p1_size, p1_signed, p1_addr, p1_wdata, p1_gnt, p1_rvalid, p1_rdata, p1_err: identical to the port 0 signals.
- dm_wena  out  1  DMEM write enable.
- dm_in_type  out  2  DMEM size code.
- dm_addr_tail  out  2  byte offset, addr[1:0].
- dm_addr  out  AW  word address, addr[AW+1:2].
- dm_data32  out  32  DMEM word write data.
- dm_data16  out  16  DMEM halfword write data.
- dm_data8  out  8  DMEM byte write data.
- dm_rdata  in  32  DMEM combinational read word.

Behaviour:
- Reset (async, rst=1): state IDLE, last_grant=1 (so port 0 wins the first tie). All gnt/rvalid/err/rdata outputs and all dm_* outputs are 0 immediately.
- FSM: IDLE -> ACCESS -> RESP -> IDLE.
- IDLE, arbitration:
  - Only one req high: that port wins.
  - Both high: the port not granted last wins.
  - gnt is combinational in IDLE for the winner only.
  - At the rising edge the controller latches we/size/signed/addr/wdata and the port id, updates last_grant, and moves to ACCESS.
- ACCESS (1 cycle):
  - dm_addr, dm_in_type, dm_addr_tail and dm_data* are driven from the latched request.
  - dm_data16 = wdata[15:0]; dm_data8 = wdata[7:0].
  - dm_wena = we & ~bad; the write commits at the closing edge.
  - For loads, dm_rdata is sampled at the closing edge.
- bad = size==11, OR size==01 with addr[0]!=0, OR size==00 with addr[1:0]!=0, OR addr >= 4*DEPTH_WORDS.
  - When bad, dm_wena stays 0 and no DMEM location changes.
- Load extraction:
  - Word: rdata = dm_rdata.
  - Halfword: field dm_rdata[15:0] if addr[1]=0, else dm_rdata[31:16].
  - Byte: field dm_rdata[8*addr[1:0]+7 : 8*addr[1:0]].
  - Extension to 32 bits: sign-extended if signed, else zero-extended.
- RESP (1 cycle):
  - Owner port: rvalid=1, rdata (0 if store or bad), err=bad.
  - Other port's rvalid stays 0. Then IDLE.
- Requests arriving during ACCESS/RESP are ignored (no gnt) until IDLE.
- A request is never lost: the requester must hold req until gnt.
- Back-to-back: gnt spacing is exactly 3 cycles for a continuously requesting port.
- Both ports held high: grants alternate 0,1,0,1...
- dm_wena is 0 in every state except ACCESS.
- rst mid-ACCESS: the write is suppressed (wena drops asynchronously) and no rvalid is issued.
- Output timing: gnt is combinational from req and state. All other outputs come from registers or latched request fields (no req-to-dm_* combinational path).

Test Plan:
- p0 SW addr=0x10 wdata=0xDEADBEEF, then p0 LW 0x10 -> gnt, write to word 4 in ACCESS, rvalid 2 cycles after gnt. Load returns 0xDEADBEEF, err=0.
- After word 4 = 0xDEADBEEF: LB 0x13 signed -> 0xFFFFFFDE; LBU 0x13 -> 0x000000DE; LH 0x12 signed -> 0xFFFFDEAD; LHU 0x10 -> 0x0000BEEF.
- SB 0x11 wdata=0x55 then LW 0x10 -> 0xDEAD55EF; dm_in_type=10, dm_addr_tail=01 during ACCESS.
- Both ports request continuously from reset -> gnt order p0,p1,p0,p1 at cycles 0,3,6,9; each rvalid goes only to its owner.
- SW addr=0x12 and LW addr=0x80 -> err=1, rdata=0, dm_wena never asserted; a subsequent LW 0x10 is unchanged.
- Assert rst during ACCESS of SW 0x14 -> all outputs 0 at once, word 5 unchanged, no rvalid. After release, p0 wins the first tie.
